mat_vect_job_ctrl: RTL and testbench

//  Job sequencer in front of the matrix-vector multiply datapath. On start, fetches an
//  N x N row-major matrix from a sync-read memory and streams it to the datapath over
//  AXI-stream, with tlast on each row end. Collects the N row results and writes them to
//  a result memory. Signals done/err to the host.

---
 rtl/mat_vect_job_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mat_vect_job_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vect_job_ctrl.sv
// ---------------------------------------------------------------------------
// mat_vect_job_ctrl
//
// Job sequencer for the matrix-vector multiply datapath. A start pulse in IDLE
// latches the matrix and result base addresses. The block then reads the N x N
// row-major matrix from a synchronous-read memory and streams it out over
// AXI-stream, asserting tlast at the end of every row. It captures the N row
// results that come back and writes each one to the result memory. A done
// pulse ends the job. err is a sticky flag for result framing errors.
//
// Ports
//   aclk, areset        clock; asynchronous active-high reset
//   start               job request, sampled only in IDLE
//   base_addr, res_base matrix / result base addresses, latched on start
//   busy, done, err     host status
//   mem_rd_en/addr/rdata  matrix memory read port (read data 1 cycle later)
//   m_axis_*            element stream to the datapath
//   s_axis_*            row results from the datapath (tready = busy)
//   res_wr_en/addr/wdata  result memory write port
// ---------------------------------------------------------------------------
module mat_vect_job_ctrl #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [AW-1:0]             res_base,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      mem_rd_en,
    output logic [AW-1:0]             mem_addr,
    input  logic [DW-1:0]             mem_rdata,
    output logic [DW-1:0]             m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic [2*DW+$clog2(N)-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic                      res_wr_en,
    output logic [AW-1:0]             res_addr,
    output logic [2*DW+$clog2(N)-1:0] res_wdata
);

    localparam int RW   = 2*DW + $clog2(N);
    localparam int NN   = N*N;
    localparam int CW   = $clog2(NN+1);
    localparam int COLW = $clog2(N);
    localparam int RCW  = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            busy_q, done_q, err_q;
    logic [AW-1:0]   base_q, res_base_q;

    // Fetch pipeline: read strobe, then read-data-valid stage that pushes.
    logic [CW-1:0]   rd_cnt_q;
    logic            mem_rd_en_q;
    logic [AW-1:0]   mem_addr_q;
    logic            rvld_q;

    // Two-entry output FIFO.
    logic [DW-1:0]   fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;

    // Stream side.
    logic [COLW-1:0] col_q;
    logic [CW-1:0]   sent_q;

    // Result side.
    logic [RCW-1:0]  res_cnt_q;
    logic            res_wr_en_q;
    logic [AW-1:0]   res_addr_q;
    logic [RW-1:0]   res_wdata_q;

    logic            push, pop, s_hs, issue_rd, last_col;
    logic [2:0]      occ;

    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = rvld_q;
    assign s_hs          = s_axis_tvalid && busy_q;
    assign last_col      = (col_q == COLW'(N-1));
    assign fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    // Worst-case FIFO fill once every read already issued has landed. A new
    // read is only issued when it is guaranteed a free slot, so the FIFO can
    // never overflow whatever tready does. The pop of this cycle is certain,
    // so it may be credited.
    assign occ      = {1'b0, fifo_cnt_q} + {2'b00, mem_rd_en_q} + {2'b00, rvld_q} - {2'b00, pop};
    assign issue_rd = (state_q == RUN) && (rd_cnt_q < CW'(NN)) && (occ < 3'd2);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            base_q      <= '0;
            res_base_q  <= '0;
            rd_cnt_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rvld_q      <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            col_q       <= '0;
            sent_q      <= '0;
            res_cnt_q   <= '0;
            res_wr_en_q <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
        end else begin
            mem_rd_en_q <= 1'b0;
            res_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            rvld_q      <= mem_rd_en_q;

            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                sent_q   <= sent_q + CW'(1);
                col_q    <= last_col ? '0 : col_q + COLW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;

            // Beats beyond the N-th in a job are absorbed without a write.
            if (s_hs && (res_cnt_q < RCW'(N))) begin
                res_wr_en_q <= 1'b1;
                res_addr_q  <= res_base_q + AW'(res_cnt_q);
                res_wdata_q <= s_axis_tdata;
                res_cnt_q   <= res_cnt_q + RCW'(1);
                if (s_axis_tlast != (res_cnt_q == RCW'(N-1))) begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        base_q      <= base_addr;
                        res_base_q  <= res_base;
                        sent_q      <= '0;
                        col_q       <= '0;
                        res_cnt_q   <= '0;
                        // First read goes out straight from the start edge.
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= base_addr;
                        rd_cnt_q    <= CW'(1);
                    end
                end
                RUN: begin
                    if (issue_rd) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= base_q + AW'(rd_cnt_q);
                        rd_cnt_q    <= rd_cnt_q + CW'(1);
                    end
                    if ((sent_q == CW'(NN)) && (res_cnt_q == RCW'(N))) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign mem_rd_en     = mem_rd_en_q;
    assign mem_addr      = mem_addr_q;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_col;
    assign s_axis_tready = busy_q;
    assign res_wr_en     = res_wr_en_q;
    assign res_addr      = res_addr_q;
    assign res_wdata     = res_wdata_q;

endmodule

// File: tb/tb_mat_vect_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mat_vect_job_ctrl
//
// Bench for mat_vect_job_ctrl (N=2, DW=8, AW=8). It provides a sync-read
// matrix memory, a datapath that multiplies each streamed row by a fixed
// vector, and a result memory. A job-level model predicts the read addresses,
// the element stream, the result writes, busy/done/err, and the FIFO bound.
// It is checked every cycle on the falling edge. Directed jobs add literal
// expectations.
// ---------------------------------------------------------------------------
module tb_mat_vect_job_ctrl;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RW = 2*DW + $clog2(N);
    localparam int NN = N*N;

    logic          aclk = 1'b0;
    logic          areset, start;
    logic [AW-1:0] base_addr, res_base;
    logic          busy, done, err, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [RW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          res_wr_en;
    logic [AW-1:0] res_addr;
    logic [RW-1:0] res_wdata;

    mat_vect_job_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .base_addr(base_addr), .res_base(res_base),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment state.
    logic [7:0]    mem [256];
    logic [RW-1:0] resmem [256];
    int            vect [N];
    logic          rand_mode = 1'b0;
    logic          tready_fix = 1'b1;
    logic          bad_tlast = 1'b0;
    logic          rd_pend = 1'b0;
    logic [7:0]    rd_a = '0;
    logic          s_hs_seen = 1'b0;
    int            dp_q [$];
    int            dp_acc = 0;
    int            dp_col = 0;
    int            dp_row = 0;

    // Job model state.
    logic          job_act = 1'b0;
    logic          done_exp = 1'b0;
    logic          err_exp = 1'b0;
    logic [7:0]    job_base, job_res;
    logic [RW-1:0] exp_res [N];
    int            rd_idx, beat_idx, res_idx;
    logic          pend_wr = 1'b0;
    logic [7:0]    pend_addr;
    logic [RW-1:0] pend_data;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [7:0]    rd_log [8];
    int            done_cnt = 0;
    int            beats_total = 0;
    logic          was_act, nxt_done;

    // Memory read data, ready pattern and datapath result driver.
    always @(posedge aclk) begin
        #1;
        mem_rdata     = rd_pend ? mem[rd_a] : 8'($urandom);
        m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_fix;
        if (areset) begin
            s_axis_tvalid = 1'b0;
            dp_row        = 0;
        end else if (s_axis_tvalid && s_hs_seen) begin
            s_axis_tvalid = 1'b0;
        end else if (!s_axis_tvalid && dp_q.size() > 0) begin
            s_axis_tdata  = RW'(dp_q.pop_front());
            s_axis_tlast  = bad_tlast ? 1'b1 : (dp_row == N-1);
            s_axis_tvalid = 1'b1;
            dp_row        = (dp_row == N-1) ? 0 : dp_row + 1;
        end
    end

    // Datapath element sink: row dot product with vect.
    always @(negedge aclk) begin
        if (areset) begin
            dp_q.delete();
            dp_acc = 0;
            dp_col = 0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            dp_acc += int'(m_axis_tdata) * vect[dp_col];
            if (m_axis_tlast) begin
                dp_q.push_back(dp_acc);
                dp_acc = 0;
                dp_col = 0;
            end else begin
                dp_col++;
            end
        end
    end

    // Compare process: outputs against the job model, every cycle.
    always @(negedge aclk) begin
        if (areset) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_rd_en", 32'(mem_rd_en), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_tvalid", 32'(m_axis_tvalid), 0);
            chk("rst_tdata", 32'(m_axis_tdata), 0);
            chk("rst_tlast", 32'(m_axis_tlast), 0);
            chk("rst_s_tready", 32'(s_axis_tready), 0);
            chk("rst_wr_en", 32'(res_wr_en), 0);
            chk("rst_res_addr", 32'(res_addr), 0);
            chk("rst_res_wdata", 32'(res_wdata), 0);
            job_act = 1'b0; done_exp = 1'b0; err_exp = 1'b0;
            pend_wr = 1'b0; prev_stall = 1'b0; rd_pend = 1'b0; s_hs_seen = 1'b0;
        end else begin
            was_act = job_act;
            chk("busy", 32'(busy), 32'(job_act));
            chk("s_tready", 32'(s_axis_tready), 32'(job_act));
            chk("done", 32'(done), 32'(done_exp));
            chk("err", 32'(err), 32'(err_exp));
            chk("res_wr_en", 32'(res_wr_en), 32'(pend_wr));
            if (pend_wr) begin
                chk("res_addr", 32'(res_addr), 32'(pend_addr));
                chk("res_wdata", 32'(res_wdata), 32'(pend_data));
            end
            if (res_wr_en) resmem[res_addr] = res_wdata;
            if (done) done_cnt++;
            pend_wr  = 1'b0;
            nxt_done = job_act && !done_exp && (beat_idx == NN) && (res_idx == N);

            if (mem_rd_en) begin
                chk("rd_in_job", 32'(job_act && rd_idx < NN), 1);
                chk("rd_addr", 32'(mem_addr), 32'(8'(job_base + rd_idx)));
                if (rd_idx < 8) rd_log[rd_idx] = mem_addr;
                rd_idx++;
            end
            if (job_act) chk("fifo_bound", 32'(rd_idx - beat_idx <= 2), 1);
            if (!job_act) chk("idle_tvalid", 32'(m_axis_tvalid), 0);
            if (prev_stall) begin
                chk("stall_tvalid", 32'(m_axis_tvalid), 1);
                chk("stall_tdata", 32'(m_axis_tdata), 32'(prev_data));
                chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk("tdata", 32'(m_axis_tdata), 32'(mem[8'(job_base + beat_idx)]));
                chk("tlast", 32'(m_axis_tlast), 32'((beat_idx % N) == N-1));
                beat_idx++;
                beats_total++;
            end
            if (s_axis_tvalid && s_axis_tready && res_idx < N) begin
                pend_wr   = 1'b1;
                pend_addr = 8'(job_res + res_idx);
                pend_data = exp_res[res_idx];
                if (s_axis_tlast != (res_idx == N-1)) err_exp = 1'b1;
                res_idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            rd_pend    = mem_rd_en;
            rd_a       = mem_addr;
            s_hs_seen  = s_axis_tvalid && s_axis_tready;

            if (done_exp) job_act = 1'b0;
            if (start && !was_act) begin
                job_act  = 1'b1;
                err_exp  = 1'b0;
                job_base = base_addr;
                job_res  = res_base;
                rd_idx = 0; beat_idx = 0; res_idx = 0;
                for (int r = 0; r < N; r++) begin
                    int s;
                    s = 0;
                    for (int c = 0; c < N; c++) s += int'(mem[8'(base_addr + r*N + c)]) * vect[c];
                    exp_res[r] = RW'(s);
                end
            end
            done_exp = nxt_done;
        end
    end

    int   job_dn0, job_bt0;
    logic err_at_start;

    task automatic run_job(input logic [7:0] b, input logic [7:0] rb, input logic restart);
        int i;
        @(posedge aclk); #1;
        base_addr = b; res_base = rb; start = 1'b1;
        job_dn0 = done_cnt; job_bt0 = beats_total;
        @(posedge aclk); #1 start = 1'b0;
        @(negedge aclk) err_at_start = err;
        if (restart) begin
            repeat (2) @(posedge aclk);
            #1 start = 1'b1;
            @(posedge aclk); #1 start = 1'b0;
        end
        for (i = 0; i < 400; i++) begin
            if (done_cnt != job_dn0) break;
            @(negedge aclk);
        end
        chk("job_finished", 32'(done_cnt != job_dn0), 1);
        repeat (4) @(negedge aclk);
        chk("done_pulses", 32'(done_cnt - job_dn0), 1);
        chk("beats_per_job", 32'(beats_total - job_bt0), NN);
    endtask

    task automatic load_matrix(input logic [7:0] b, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        mem[b] = e0; mem[8'(b+1)] = e1; mem[8'(b+2)] = e2; mem[8'(b+3)] = e3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        areset = 1'b1; start = 1'b0; base_addr = '0; res_base = '0;
        m_axis_tready = 1'b1; mem_rdata = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        vect[0] = 5; vect[1] = 6;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'($urandom);
            resmem[i] = '1;
        end
        load_matrix(8'h10, 8'd1, 8'd2, 8'd3, 8'd4);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tvalid", 32'(m_axis_tvalid), 0);
        @(posedge aclk); #1 areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Basic job, tready always high.
        run_job(8'h10, 8'h40, 1'b0);
        chk("j1_row0", 32'(resmem[8'h40]), 17);
        chk("j1_row1", 32'(resmem[8'h41]), 39);
        chk("j1_err", 32'(err), 0);
        chk("j1_rd2_addr", 32'(rd_log[2]), 32'h12);

        // Random backpressure.
        rand_mode = 1'b1;
        run_job(8'h10, 8'h50, 1'b0);
        rand_mode = 1'b0;
        chk("j2_row0", 32'(resmem[8'h50]), 17);
        chk("j2_row1", 32'(resmem[8'h51]), 39);

        // Datapath flags tlast on row 0 as well: framing error, job completes.
        bad_tlast = 1'b1;
        run_job(8'h10, 8'h90, 1'b0);
        bad_tlast = 1'b0;
        chk("j3_err_sticky", 32'(err), 1);
        chk("j3_row0", 32'(resmem[8'h90]), 17);
        chk("j3_row1", 32'(resmem[8'h91]), 39);

        // Second start during RUN is ignored; the new start clears err.
        run_job(8'h10, 8'hA0, 1'b1);
        chk("j4_err_cleared", 32'(err_at_start), 0);
        chk("j4_row1", 32'(resmem[8'hA1]), 39);

        // Matrix address wraps past 0xFF.
        load_matrix(8'hFE, 8'd7, 8'd8, 8'd9, 8'd10);
        run_job(8'hFE, 8'h80, 1'b0);
        chk("j5_rd0", 32'(rd_log[0]), 32'hFE);
        chk("j5_rd1", 32'(rd_log[1]), 32'hFF);
        chk("j5_rd2", 32'(rd_log[2]), 32'h00);
        chk("j5_rd3", 32'(rd_log[3]), 32'h01);
        chk("j5_row0", 32'(resmem[8'h80]), 83);
        chk("j5_row1", 32'(resmem[8'h81]), 105);

        // Abort mid-stream, then a clean job.
        load_matrix(8'h10, 8'd1, 8'd2, 8'd3, 8'd4);
        job_bt0 = beats_total;
        @(posedge aclk); #1;
        base_addr = 8'h10; res_base = 8'h70; start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (beats_total != job_bt0) break;
            @(negedge aclk);
        end
        chk("abort_stream_started", 32'(beats_total != job_bt0), 1);
        @(posedge aclk); #1 areset = 1'b1;
        @(negedge aclk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tvalid", 32'(m_axis_tvalid), 0);
        chk("abort_rd_en", 32'(mem_rd_en), 0);
        chk("abort_wr_en", 32'(res_wr_en), 0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        run_job(8'h10, 8'h60, 1'b0);
        chk("j6_row0", 32'(resmem[8'h60]), 17);
        chk("j6_row1", 32'(resmem[8'h61]), 39);
        chk("j6_no_residual0", 32'(resmem[8'h70]), 32'h1FFFF);
        chk("j6_no_residual1", 32'(resmem[8'h71]), 32'h1FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
